servant_sleep_ctrl: RTL
=======================

// Module: servant_sleep_ctrl
// PURPOSE
//  Always-on sleep/wakeup controller feeding the core clock gate.
//  - Takes the CPU sleep request (WFI) and external interrupt lines.
//  - Drains any in-flight bus cycle, then deasserts o_clk_en.
//  - Re-enables o_clk_en on a masked interrupt or on wake-timer expiry, after a settle delay.
//  - Runs on the ungated clock; configured through a small Wishbone slave.
// PARAMETERS
//  IRQ_W          4   number of wakeup interrupt sources
//  TIMER_W        32  width of wake timer; TIMER value 0 = timer disabled
//  SETTLE_CYCLES  4   cycles o_clk_en stays low in WAKE before release (>=1)
// PORTS
//  i_clk       in   1        free-running clock, never gated
//  i_rst       in   1        asynchronous reset, active-high
//  i_sleep_req in   1        1-cycle pulse from core requesting sleep
//  i_bus_busy  in   1        core bus cycle in flight
//  i_irq       in   IRQ_W    level-sensitive interrupt sources, synchronous to i_clk
//  i_wb_adr    in   2        word address: 0 MASK, 1 TIMER, 2 STATUS, 3 reserved (reads 0)
//  i_wb_dat    in   32       write data
//  i_wb_we     in   1        write enable
//  i_wb_cyc    in   1        cycle valid
//  i_wb_stb    in   1        strobe
//  o_wb_rdt    out  32       read data, valid with o_wb_ack
//  o_wb_ack    out  1        1-cycle acknowledge
//  o_clk_en    out  1        registered enable to the core clock gate; 1 = core clocked
//  o_wakeup    out  1        1-cycle pulse when o_clk_en returns high
//  o_state     out  2        current FSM state (debug)
// BEHAVIOUR
//  Reset values
//  - State RUN; o_clk_en=1; o_wakeup=0; o_wb_ack=0; o_wb_rdt=0.
//  - MASK=0, TIMER=0, STATUS=0.
//  FSM: RUN(0) -> DRAIN(1) -> SLEEP(2) -> WAKE(3) -> RUN
//  - RUN
//    - i_sleep_req with (i_irq & MASK) != 0: stay in RUN. STATUS[IRQ_W-1:0] |= pending masked irqs.
//    - i_sleep_req with MASK==0 and TIMER==0: refused, stay in RUN. STATUS[30] = 1 (deadlock guard).
//    - Otherwise go to DRAIN.
//  - DRAIN: first cycle with i_bus_busy==0 -> o_clk_en<=0, cnt<=TIMER, go to SLEEP.
//  - SLEEP
//    - If TIMER != 0, cnt decrements each cycle. Expiry is cnt==1 at decrement, so exactly TIMER SLEEP cycles.
//    - Wake on expiry or on (i_irq & MASK) != 0.
//    - On wake: STATUS[IRQ_W-1:0] |= masked irqs; STATUS[31] = 1 on timer expiry. Irq and expiry in the same cycle set both.
//    - Go to WAKE; settle counter <= SETTLE_CYCLES.
//  - WAKE
//    - o_clk_en stays 0 for exactly SETTLE_CYCLES cycles.
//    - Then o_clk_en<=1 and o_wakeup=1 for one cycle, go to RUN.
//  - i_sleep_req outside RUN is ignored. i_irq changes during DRAIN do not abort the drain.
//  Wishbone
//  - o_wb_ack = registered (cyc & stb & !ack): 1-cycle latency, no back-to-back ack.
//  - Accesses are served in every state.
//  - STATUS is write-1-to-clear. A hardware set in the same cycle wins over the clear.
//  - MASK uses bits [IRQ_W-1:0]; other bits read 0.
//  - TIMER is sampled only on DRAIN->SLEEP; a write during SLEEP does not affect the current sleep.
//  Reset mid-operation: i_rst in any state forces RUN with o_clk_en=1 immediately (async), and clears all registers.
// STRUCTURE
//  - Package servant_sleep_pkg:
//    - state typedef (RUN/DRAIN/SLEEP/WAKE) with the encodings above;
//    - register address localparams;
//    - STATUS bit positions (TIMER_BIT=31, REFUSE_BIT=30).
//  - Sub-module servant_sleep_regs: Wishbone decode, MASK/TIMER/STATUS storage, W1C and set priority.
//  - FSM, wake counter and settle counter stay in the top module.
// TESTING
//  1. Sleep refused: reset, MASK=0, TIMER=0, pulse i_sleep_req
//     -> o_clk_en stays 1, STATUS reads 0x4000_0000.
//  2. Irq wake: MASK=0x2, pulse i_sleep_req with i_bus_busy=0
//     -> o_clk_en=0 two cycles later.
//     Raise i_irq=0x2 -> o_clk_en=1 after 4 settle cycles, o_wakeup pulses once, STATUS=0x2.
//  3. Timer wake: TIMER=10, MASK=0, sleep
//     -> exactly 10 SLEEP cycles, then 4 WAKE cycles, then STATUS=0x8000_0000.
//  4. Drain: hold i_bus_busy=1 for 7 cycles after i_sleep_req
//     -> o_clk_en stays 1 until the cycle after busy drops.
//  5. Collisions:
//     - irq on the timer-expiry cycle -> STATUS sets both bits;
//     - W1C of STATUS on the same cycle as a set -> the bit remains 1.
//  6. Async reset asserted mid-SLEEP -> o_clk_en=1 without a clock edge; state RUN; all registers 0.

Source files
------------

// File: rtl/servant_sleep_pkg.sv
// Shared types and constants for the servant sleep/wakeup controller.
package servant_sleep_pkg;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StDrain = 2'd1,
      StSleep = 2'd2,
      StWake  = 2'd3
   } state_e;

   localparam logic [1:0] ADR_MASK   = 2'd0;
   localparam logic [1:0] ADR_TIMER  = 2'd1;
   localparam logic [1:0] ADR_STATUS = 2'd2;

   localparam int unsigned TIMER_BIT  = 31;
   localparam int unsigned REFUSE_BIT = 30;

endpackage

// File: rtl/servant_sleep_regs.sv
// Wishbone register file: MASK, TIMER and write-1-to-clear STATUS.
module servant_sleep_regs
   import servant_sleep_pkg::*;
#(
   parameter int unsigned IRQ_W   = 4,
   parameter int unsigned TIMER_W = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [1:0]         i_wb_adr,
   input  logic [31:0]        i_wb_dat,
   input  logic               i_wb_we,
   input  logic               i_wb_cyc,
   input  logic               i_wb_stb,
   output logic [31:0]        o_wb_rdt,
   output logic               o_wb_ack,
   input  logic [IRQ_W-1:0]   i_set_irq,
   input  logic               i_set_timer,
   input  logic               i_set_refuse,
   output logic [IRQ_W-1:0]   o_mask,
   output logic [TIMER_W-1:0] o_timer
);

   logic               ack_q;
   logic [31:0]        rdt_q;
   logic [IRQ_W-1:0]   mask_q;
   logic [TIMER_W-1:0] timer_q;
   logic [IRQ_W-1:0]   st_irq_q, st_irq_d;
   logic               st_tmr_q, st_tmr_d;
   logic               st_ref_q, st_ref_d;
   logic               req;
   logic [31:0]        clr;
   logic [31:0]        rdata;

   always_comb begin
      req = i_wb_cyc & i_wb_stb & ~ack_q;
      clr = '0;
      if (req && i_wb_we && (i_wb_adr == ADR_STATUS)) clr = i_wb_dat;
      // Hardware set is OR-ed in after the clear so it wins on a collision.
      st_irq_d = (st_irq_q & ~clr[IRQ_W-1:0]) | i_set_irq;
      st_tmr_d = (st_tmr_q & ~clr[TIMER_BIT]) | i_set_timer;
      st_ref_d = (st_ref_q & ~clr[REFUSE_BIT]) | i_set_refuse;
   end

   always_comb begin
      rdata = '0;
      case (i_wb_adr)
         ADR_MASK:   rdata[IRQ_W-1:0] = mask_q;
         ADR_TIMER:  rdata[TIMER_W-1:0] = timer_q;
         ADR_STATUS: begin
            rdata[IRQ_W-1:0]  = st_irq_q;
            rdata[TIMER_BIT]  = st_tmr_q;
            rdata[REFUSE_BIT] = st_ref_q;
         end
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ack_q    <= 1'b0;
         rdt_q    <= '0;
         mask_q   <= '0;
         timer_q  <= '0;
         st_irq_q <= '0;
         st_tmr_q <= 1'b0;
         st_ref_q <= 1'b0;
      end else begin
         ack_q    <= req;
         rdt_q    <= req ? rdata : '0;
         st_irq_q <= st_irq_d;
         st_tmr_q <= st_tmr_d;
         st_ref_q <= st_ref_d;
         if (req && i_wb_we && (i_wb_adr == ADR_MASK))  mask_q  <= i_wb_dat[IRQ_W-1:0];
         if (req && i_wb_we && (i_wb_adr == ADR_TIMER)) timer_q <= i_wb_dat[TIMER_W-1:0];
      end
   end

   assign o_wb_ack = ack_q;
   assign o_wb_rdt = rdt_q;
   assign o_mask   = mask_q;
   assign o_timer  = timer_q;

endmodule

// File: rtl/servant_sleep_ctrl.sv
// Always-on sleep controller: drains the bus, gates the core clock, wakes on irq or timer.
module servant_sleep_ctrl
   import servant_sleep_pkg::*;
#(
   parameter int unsigned IRQ_W         = 4,
   parameter int unsigned TIMER_W       = 32,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_sleep_req,
   input  logic             i_bus_busy,
   input  logic [IRQ_W-1:0] i_irq,
   input  logic [1:0]       i_wb_adr,
   input  logic [31:0]      i_wb_dat,
   input  logic             i_wb_we,
   input  logic             i_wb_cyc,
   input  logic             i_wb_stb,
   output logic [31:0]      o_wb_rdt,
   output logic             o_wb_ack,
   output logic             o_clk_en,
   output logic             o_wakeup,
   output logic [1:0]       o_state
);

   localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   cnt_q, cnt_d;
   logic [SETTLE_W-1:0]  settle_q, settle_d;
   logic                 clk_en_q, clk_en_d;
   logic                 wakeup_q, wakeup_d;
   logic [IRQ_W-1:0]     mask;
   logic [TIMER_W-1:0]   timer;
   logic [IRQ_W-1:0]     pend;
   logic                 expire;
   logic [IRQ_W-1:0]     set_irq;
   logic                 set_timer;
   logic                 set_refuse;

   servant_sleep_regs #(
      .IRQ_W   (IRQ_W),
      .TIMER_W (TIMER_W)
   ) u_regs (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_wb_adr     (i_wb_adr),
      .i_wb_dat     (i_wb_dat),
      .i_wb_we      (i_wb_we),
      .i_wb_cyc     (i_wb_cyc),
      .i_wb_stb     (i_wb_stb),
      .o_wb_rdt     (o_wb_rdt),
      .o_wb_ack     (o_wb_ack),
      .i_set_irq    (set_irq),
      .i_set_timer  (set_timer),
      .i_set_refuse (set_refuse),
      .o_mask       (mask),
      .o_timer      (timer)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      settle_d   = settle_q;
      clk_en_d   = clk_en_q;
      wakeup_d   = 1'b0;
      set_irq    = '0;
      set_timer  = 1'b0;
      set_refuse = 1'b0;
      pend       = i_irq & mask;
      // cnt is zero only when the timer was disabled at sleep entry.
      expire     = (cnt_q == TIMER_W'(1));
      unique case (state_q)
         StRun: begin
            if (i_sleep_req) begin
               if (|pend) begin
                  set_irq = pend;
               end else if ((mask == '0) && (timer == '0)) begin
                  set_refuse = 1'b1;
               end else begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (!i_bus_busy) begin
               clk_en_d = 1'b0;
               cnt_d    = timer;
               state_d  = StSleep;
            end
         end
         StSleep: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            if (expire || (|pend)) begin
               set_irq   = pend;
               set_timer = expire;
               settle_d  = SETTLE_W'(SETTLE_CYCLES);
               state_d   = StWake;
            end
         end
         StWake: begin
            if (settle_q == SETTLE_W'(1)) begin
               clk_en_d = 1'b1;
               wakeup_d = 1'b1;
               state_d  = StRun;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= StRun;
         cnt_q    <= '0;
         settle_q <= '0;
         clk_en_q <= 1'b1;
         wakeup_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         clk_en_q <= clk_en_d;
         wakeup_q <= wakeup_d;
      end
   end

   assign o_clk_en = clk_en_q;
   assign o_wakeup = wakeup_q;
   assign o_state  = state_q;

endmodule
